// File: rtl/r500_ctrl_pkg.sv
// Shared encodings and the control-bundle type for the R500 decode stage.
package r500_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned VR_W  = 3;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [1:0] ALU_FUNCT = 2'd0;
  localparam logic [1:0] ALU_ADD   = 2'd1;
  localparam logic [1:0] ALU_SUB   = 2'd2;

  localparam logic [1:0] SRC_ALU   = 2'd0;
  localparam logic [1:0] SRC_MEM   = 2'd1;
  localparam logic [1:0] SRC_PCIMM = 2'd2;
  localparam logic [1:0] SRC_PC4   = 2'd3;

  // Bit positions inside valid_reg ({rs2, rs1, rd}).
  localparam int unsigned VR_RD  = 0;
  localparam int unsigned VR_RS1 = 1;
  localparam int unsigned VR_RS2 = 2;

  typedef struct packed {
    logic [1:0]       alu_op;
    logic [1:0]       reg_src;
    logic             alu_src;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             branch;
    logic             jump;
    logic             muldiv;
    logic             illegal;
    logic [VR_W-1:0]  valid_reg;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I (+ optional M) opcode decode into the control bundle.
module ctrl_decode
  import r500_ctrl_pkg::*;
#(
  parameter bit EN_M = 1'b0
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  ctrl_t      dec;
  logic       legal;
  logic [6:0] funct7;
  logic       unused_funct3;

  assign funct7        = instr[31:25];
  assign unused_funct3 = ^instr[14:12];

  // Opcode table; a listed opcode already implies instr[1:0] == 2'b11.
  always_comb begin
    dec       = '0;
    legal     = 1'b1;
    dec.rs1   = instr[19:15];
    dec.rs2   = instr[24:20];
    dec.rd    = instr[11:7];
    case (instr[6:0])
      OP_R: begin
        legal         = (funct7 == F7_BASE) || (funct7 == F7_ALT) ||
                        (EN_M && (funct7 == F7_MULDIV));
        dec.muldiv    = EN_M && (funct7 == F7_MULDIV);
        dec.reg_write = 1'b1;
        dec.valid_reg = 3'b111;
      end
      OP_I_ALU: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.valid_reg = 3'b011;
      end
      OP_LOAD: begin
        dec.alu_op    = ALU_ADD;
        dec.reg_src   = SRC_MEM;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
        dec.valid_reg = 3'b011;
      end
      OP_JALR: begin
        dec.alu_op    = ALU_ADD;
        dec.reg_src   = SRC_PC4;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
        dec.valid_reg = 3'b011;
      end
      OP_FENCE: dec.valid_reg = 3'b011;
      OP_STORE: begin
        dec.alu_op    = ALU_ADD;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.valid_reg = 3'b110;
      end
      OP_LUI: begin
        dec.alu_op    = ALU_ADD;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.valid_reg = 3'b001;
      end
      OP_AUIPC: begin
        dec.reg_src   = SRC_PCIMM;
        dec.reg_write = 1'b1;
        dec.valid_reg = 3'b001;
      end
      OP_JAL: begin
        dec.reg_src   = SRC_PC4;
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
        dec.valid_reg = 3'b001;
      end
      OP_BRANCH: begin
        dec.alu_op    = ALU_SUB;
        dec.branch    = 1'b1;
        dec.valid_reg = 3'b110;
      end
      default: legal = 1'b0;
    endcase
    if (dec.rd == '0) dec.reg_write = 1'b0;
  end

  // Illegal encodings keep only the raw register fields so EX can trap.
  always_comb begin
    ctrl = dec;
    if (!legal) begin
      ctrl         = '0;
      ctrl.rs1     = dec.rs1;
      ctrl.rs2     = dec.rs2;
      ctrl.rd      = dec.rd;
      ctrl.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered decode stage: valid/ready pipeline register, load-use bubble,
// flush and a saturating illegal-instruction counter.
module decode_ctrl_stage
  import r500_ctrl_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter bit          EN_M      = 1'b0,
  parameter bit          EN_HAZARD = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [2:0]       out_valid_reg,
  output logic [1:0]       out_alu_op,
  output logic [1:0]       out_reg_src,
  output logic             out_alu_src,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic             out_branch,
  output logic             out_jump,
  output logic             out_muldiv,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  ctrl_t            dec;
  ctrl_t            held;
  logic             valid_q;
  logic [XLEN-1:0]  pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             hazard;
  logic             accept;

  ctrl_decode #(.EN_M(EN_M)) u_decode (
    .instr (in_instr),
    .ctrl  (dec)
  );

  // Held load whose rd feeds a source of the incoming instruction.
  always_comb begin
    hazard = EN_HAZARD && in_valid && valid_q && held.mem_read &&
             (held.rd != '0) &&
             ((dec.valid_reg[VR_RS1] && (dec.rs1 == held.rd)) ||
              (dec.valid_reg[VR_RS2] && (dec.rs2 == held.rd)));
  end

  assign in_ready = !flush && !hazard && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // A drained or empty register takes the new bundle, or a bubble if none.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      held    <= '0;
      pc_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      held    <= '0;
      pc_q    <= '0;
    end else if (!valid_q || out_ready) begin
      valid_q <= accept;
      held    <= accept ? dec : '0;
      pc_q    <= accept ? in_pc : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (accept && dec.illegal && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_valid     = valid_q;
  assign out_pc        = pc_q;
  assign out_rs1       = held.rs1;
  assign out_rs2       = held.rs2;
  assign out_rd        = held.rd;
  assign out_valid_reg = held.valid_reg;
  assign out_alu_op    = held.alu_op;
  assign out_reg_src   = held.reg_src;
  assign out_alu_src   = held.alu_src;
  assign out_reg_write = held.reg_write;
  assign out_mem_read  = held.mem_read;
  assign out_mem_write = held.mem_write;
  assign out_branch    = held.branch;
  assign out_jump      = held.jump;
  assign out_muldiv    = held.muldiv;
  assign out_illegal   = held.illegal;
  assign illegal_cnt   = cnt_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Self-checking bench: cycle model of the decode stage plus directed scenarios.
module tb_decode_ctrl_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_ready, flush = 1'b0, out_ready = 1'b1;
  logic [31:0] in_instr = '0, in_pc = 32'h1000;
  logic        out_valid, out_alu_src, out_reg_write, out_mem_read, out_mem_write;
  logic        out_branch, out_jump, out_muldiv, out_illegal;
  logic [31:0] out_pc;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [2:0]  out_valid_reg;
  logic [1:0]  out_alu_op, out_reg_src;
  logic [15:0] illegal_cnt;

  logic        b_in_valid = 1'b0, b_in_ready, b_flush = 1'b0, b_out_ready = 1'b1;
  logic [31:0] b_in_instr = '0, b_in_pc = '0;
  logic        b_out_valid, b_out_alu_src, b_out_reg_write, b_out_mem_read, b_out_mem_write;
  logic        b_out_branch, b_out_jump, b_out_muldiv, b_out_illegal;
  logic [31:0] b_out_pc;
  logic [4:0]  b_out_rs1, b_out_rs2, b_out_rd;
  logic [2:0]  b_out_valid_reg;
  logic [1:0]  b_out_alu_op, b_out_reg_src;
  logic [1:0]  b_illegal_cnt;

  decode_ctrl_stage #(.XLEN(32), .EN_M(1'b0), .EN_HAZARD(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_valid_reg(out_valid_reg), .out_alu_op(out_alu_op),
    .out_reg_src(out_reg_src), .out_alu_src(out_alu_src), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_branch(out_branch),
    .out_jump(out_jump), .out_muldiv(out_muldiv), .out_illegal(out_illegal),
    .illegal_cnt(illegal_cnt)
  );

  decode_ctrl_stage #(.XLEN(32), .EN_M(1'b1), .EN_HAZARD(1'b1), .CNT_W(2)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_instr(b_in_instr), .in_pc(b_in_pc), .flush(b_flush), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_pc(b_out_pc), .out_rs1(b_out_rs1), .out_rs2(b_out_rs2),
    .out_rd(b_out_rd), .out_valid_reg(b_out_valid_reg), .out_alu_op(b_out_alu_op),
    .out_reg_src(b_out_reg_src), .out_alu_src(b_out_alu_src),
    .out_reg_write(b_out_reg_write), .out_mem_read(b_out_mem_read),
    .out_mem_write(b_out_mem_write), .out_branch(b_out_branch), .out_jump(b_out_jump),
    .out_muldiv(b_out_muldiv), .out_illegal(b_out_illegal), .illegal_cnt(b_illegal_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] rs2,
                                     input logic [4:0] rs1, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  // Reference decode straight from the table:
  // {illegal, muldiv, alu_op, reg_src, alu_src, reg_write, mem_read, mem_write, branch, jump, valid_reg}
  function automatic logic [14:0] ref_ctrl(input logic [31:0] ins, input bit en_m);
    logic [12:0] t;
    logic [6:0]  f7;
    bit          ok;
    bit          md;
    f7 = ins[31:25];
    ok = 1'b1;
    md = 1'b0;
    t  = '0;
    case (ins[6:0])
      7'h33: begin
        t  = {2'd0, 2'd0, 1'b0, 1'b1, 4'b0000, 3'b111};
        ok = (f7 == 7'h00) || (f7 == 7'h20) || (en_m && f7 == 7'h01);
        md = en_m && (f7 == 7'h01);
      end
      7'h13: t = {2'd0, 2'd0, 1'b1, 1'b1, 4'b0000, 3'b011};
      7'h03: t = {2'd1, 2'd1, 1'b1, 1'b1, 4'b1000, 3'b011};
      7'h67: t = {2'd1, 2'd3, 1'b1, 1'b1, 4'b0001, 3'b011};
      7'h0F: t = {2'd0, 2'd0, 1'b0, 1'b0, 4'b0000, 3'b011};
      7'h23: t = {2'd1, 2'd0, 1'b1, 1'b0, 4'b0100, 3'b110};
      7'h37: t = {2'd1, 2'd0, 1'b1, 1'b1, 4'b0000, 3'b001};
      7'h17: t = {2'd0, 2'd2, 1'b0, 1'b1, 4'b0000, 3'b001};
      7'h6F: t = {2'd0, 2'd3, 1'b0, 1'b1, 4'b0001, 3'b001};
      7'h63: t = {2'd2, 2'd0, 1'b0, 1'b0, 4'b0010, 3'b110};
      default: ok = 1'b0;
    endcase
    if (!ok) return {1'b1, 14'b0};
    if (ins[11:7] == 5'd0) t[7] = 1'b0;
    return {1'b0, md, t};
  endfunction

  // Cycle model of the stage (instance with EN_M=0, CNT_W=16).
  bit          m_valid = 1'b0;
  logic [14:0] m_ctrl = '0;
  logic [31:0] m_instr = '0, m_pc = '0;
  int          m_cnt = 0;

  always @(negedge clk) begin
    logic [14:0] inc;
    logic [4:0]  hrd;
    bit          hz, rdy;
    if (!rst_n) begin
      m_valid = 1'b0; m_ctrl = '0; m_instr = '0; m_pc = '0; m_cnt = 0;
    end
    inc = ref_ctrl(in_instr, 1'b0);
    hrd = m_instr[11:7];
    hz  = in_valid && m_valid && m_ctrl[6] && (hrd != 5'd0) &&
          ((inc[1] && in_instr[19:15] == hrd) || (inc[2] && in_instr[24:20] == hrd));
    rdy = !flush && !hz && (!m_valid || out_ready);
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, m_valid);
    chk("illegal_cnt", illegal_cnt, m_cnt);
    if (!rst_n) begin
      chk("reset_fields", {out_pc, out_rs1, out_rs2, out_rd, out_valid_reg, out_alu_op,
                           out_reg_src, out_alu_src, out_reg_write, out_mem_read,
                           out_mem_write, out_branch, out_jump, out_muldiv, out_illegal}, 0);
    end else begin
      if (m_valid) begin
        chk("ctrl", {out_illegal, out_muldiv, out_alu_op, out_reg_src, out_alu_src,
                     out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump,
                     out_valid_reg}, m_ctrl);
        chk("regs", {out_rs1, out_rs2, out_rd},
            {m_instr[19:15], m_instr[24:20], m_instr[11:7]});
        chk("pc", out_pc, m_pc);
      end
      if (in_valid && rdy && inc[14] && m_cnt < 65535) m_cnt++;
      if (flush) m_valid = 1'b0;
      else if (!m_valid || out_ready) begin
        m_valid = in_valid && rdy;
        if (m_valid) begin m_ctrl = inc; m_instr = in_instr; m_pc = in_pc; end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic v, input logic [31:0] ins);
    in_valid = v;
    in_instr = ins;
    in_pc    = in_pc + 32'd4;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10];
    logic [6:0] op, f7;
    int k;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h0F, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h63};
    k = int'($urandom_range(0, 12));
    if (k < 10) op = ops[k];
    else if (k == 10) op = 7'($urandom);
    else if (k == 11) op = ops[$urandom_range(0, 9)] & 7'h7D;
    else op = 7'h03;
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    return mk(f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
              5'($urandom_range(0, 3)), op);
  endfunction

  localparam logic [31:0] ADD3  = 32'h0020_81B3; // add x3,x1,x2
  localparam logic [31:0] ILL7F = 32'h0000_007F;

  initial begin
    logic [31:0] beq_pc;
    bit fired;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_valid", out_valid, 0);
    chk("rst_cnt", illegal_cnt, 0);

    // Back-to-back ADD, LW, SW.
    present(1'b1, ADD3); step();
    chk("add_out", {out_valid, out_rd, out_reg_write}, {1'b1, 5'd3, 1'b1});
    present(1'b1, mk(7'h00, 5'd0, 5'd1, 3'd2, 5'd5, 7'h03)); step();
    chk("lw_out", {out_valid, out_alu_op, out_reg_src, out_mem_read, out_valid_reg},
        {1'b1, 2'd1, 2'd1, 1'b1, 3'b011});
    present(1'b1, mk(7'h00, 5'd7, 5'd2, 3'd2, 5'd4, 7'h23)); step();
    chk("sw_out", {out_valid, out_mem_write, out_reg_write}, 3'b110);
    present(1'b0, '0); step();

    // Load-use: exactly one bubble; rd=x0 gives none.
    present(1'b1, mk(7'h00, 5'd0, 5'd1, 3'd2, 5'd5, 7'h03)); step();
    present(1'b1, mk(7'h00, 5'd2, 5'd5, 3'd0, 5'd6, 7'h33)); #1;
    chk("lu_stall", in_ready, 0);
    step();
    chk("lu_bubble", {out_valid, in_ready}, 2'b01);
    step();
    chk("lu_issue", {out_valid, out_rd, out_rs1}, {1'b1, 5'd6, 5'd5});
    present(1'b1, mk(7'h00, 5'd0, 5'd1, 3'd2, 5'd0, 7'h03)); step();
    present(1'b1, mk(7'h00, 5'd2, 5'd0, 3'd0, 5'd6, 7'h33)); #1;
    chk("x0_noStall", in_ready, 1);
    step();
    chk("x0_issue", {out_valid, out_rd}, {1'b1, 5'd6});
    present(1'b0, '0); step();

    // BEQ held under backpressure.
    present(1'b1, mk(7'h00, 5'd2, 5'd1, 3'd0, 5'd8, 7'h63)); beq_pc = in_pc; step();
    out_ready = 1'b0;
    present(1'b1, ADD3);
    repeat (3) begin
      #1 chk("bp_ready", in_ready, 0);
      step();
      chk("bp_hold", {out_valid, out_branch, out_alu_op, out_pc}, {1'b1, 1'b1, 2'd2, beq_pc});
    end
    in_valid = 1'b0; out_ready = 1'b1; step();
    chk("bp_drain", out_valid, 0);

    // Flush kills held JAL and the incoming illegal.
    present(1'b1, mk(7'h00, 5'd0, 5'd0, 3'd0, 5'd1, 7'h6F)); step();
    chk("jal_out", {out_valid, out_jump, out_reg_src}, {1'b1, 1'b1, 2'd3});
    present(1'b1, ILL7F); flush = 1'b1; #1;
    chk("flush_ready", in_ready, 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out", {out_valid, illegal_cnt}, {1'b0, 16'd0});

    // Illegal opcode and MUL encoding without the M extension.
    present(1'b1, ILL7F); step();
    chk("ill_out", {out_valid, out_illegal, out_reg_write, out_valid_reg, illegal_cnt},
        {1'b1, 1'b1, 1'b0, 3'b000, 16'd1});
    present(1'b1, mk(7'h01, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33)); step();
    chk("mul_noM", {out_illegal, out_muldiv, illegal_cnt}, {1'b1, 1'b0, 16'd2});
    present(1'b0, '0); step();

    // M-extension instance with a 2-bit counter.
    b_in_valid = 1'b1; b_in_instr = mk(7'h01, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33); step();
    chk("mul_M", {b_out_valid, b_out_muldiv, b_out_reg_write, b_out_illegal, b_illegal_cnt},
        {4'b1110, 2'd0});
    b_in_instr = ILL7F;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("sat_cnt", b_illegal_cnt, (k > 3) ? 3 : k);
    end
    b_in_valid = 1'b0; step();

    // Asynchronous reset with a held LOAD.
    present(1'b1, mk(7'h00, 5'd0, 5'd1, 3'd2, 5'd5, 7'h03)); step();
    out_ready = 1'b0; present(1'b0, '0);
    chk("pre_rst", {out_valid, out_mem_read}, 2'b11);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst", {out_valid, out_mem_read, out_rd, illegal_cnt, b_illegal_cnt}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1; out_ready = 1'b1;

    // Randomized traffic checked every cycle by the model.
    fired = 1'b0;
    repeat (3000) begin
      @(negedge clk);
      fired = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (fired || !in_valid || ($urandom_range(0, 7) == 0))
        present(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, rand_instr());
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
    end
    flush = 1'b0; in_valid = 1'b0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_stage.md
Name: decode_ctrl_stage

Overview:
Registered instruction-decode control stage for the R500 pipeline. It sits between fetch (IF) and execute (EX). It accepts one 32-bit instruction per valid/ready handshake and decodes the RV32I opcode into a control bundle plus register indices. It holds the result in a pipeline register with backpressure, inserts load-use bubbles, honours branch flush, and counts illegal instructions; an optional mode also accepts the M extension.

Parameters:
XLEN, 32, width of the PC path
EN_M, 0, 1 = accept OP_R with funct7=0000001 as legal and assert out_muldiv
EN_HAZARD, 1, 1 = enable load-use stall/bubble insertion
CNT_W, 16, width of the saturating illegal-instruction counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  IF presents an instruction
in_ready  out  1  stage accepts the instruction this cycle
in_instr  in  32  instruction word
in_pc  in  XLEN  instruction address
flush  in  1  kill the held and incoming instruction (branch/jump resolved taken)
out_valid  out  1  EX-side bundle valid
out_ready  in  1  EX accepts the bundle
out_pc  out  XLEN  registered PC
out_rs1, out_rs2, out_rd  out  5 each  instr[19:15], [24:20], [11:7]
out_valid_reg  out  3  {rs2, rs1, rd} index-valid bits
out_alu_op  out  2  0 decode funct, 1 ADD, 2 SUB
out_reg_src  out  2  0 ALU, 1 memory, 2 pc+imm, 3 pc+4
out_alu_src, out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump  out  1 each  control flags
out_muldiv  out  1  M-extension op (0 when EN_M=0)
out_illegal  out  1  held instruction is not a legal encoding
illegal_cnt  out  CNT_W  accepted illegal instructions, saturating

Behaviour:
- Reset (async, rst_n=0): out_valid=0, every out_* field=0, illegal_cnt=0. The register clears immediately, not at the next edge.
- Decode table (ALUOp/RegSrc/ALUSrc/RegWrite/MemRead/MemWrite/Branch/Jump/ValidReg):
  - R: 0/0/0/1/0/0/0/0/111
  - I-ALU: 0/0/1/1/0/0/0/0/011
  - LOAD: 1/1/1/1/1/0/0/0/011
  - JALR: 1/3/1/1/0/0/0/1/011
  - FENCE: 0/0/0/0/0/0/0/0/011
  - STORE: 1/0/1/0/0/1/0/0/110
  - LUI: 1/0/1/1/0/0/0/0/001
  - AUIPC: 0/2/0/1/0/0/0/0/001
  - JAL: 0/3/0/1/0/0/0/1/001
  - BRANCH: 2/0/0/0/0/0/1/0/110
- Illegal conditions: unlisted opcode; instr[1:0]!=11; OP_R with funct7 other than 0000000/0100000 (plus 0000001 when EN_M=1).
- Illegal decode: all flags 0, valid_reg=000, out_illegal=1. The instruction still passes to EX as a valid bundle so EX can trap.
- reg_write is forced 0 when rd==0.
- Latency: 1 cycle from accept to out_valid.
- Handshake:
  - Transfer occurs when valid && ready.
  - in_ready = !flush && !hazard && (!out_valid || out_ready).
  - The output register holds all fields stable while out_valid && !out_ready.
- Load-use hazard: hazard = EN_HAZARD && in_valid && out_valid && out_mem_read && out_rd!=0 && ((rs1 valid && in rs1==out_rd) || (rs2 valid && in rs2==out_rd)).
  - When hazard && out_ready: the load transfers and the register loads a bubble (out_valid=0).
  - The next cycle the hazard term is false and the instruction is accepted. The penalty is exactly one bubble.
- Flush: the register clears at the next edge (out_valid=0). The incoming instruction is not accepted that cycle and illegal_cnt is not incremented. Flush wins over hazard and out_ready.
- illegal_cnt increments by 1 on each accepted illegal instruction and saturates at 2^CNT_W-1.
- Simultaneous accept and drain: the new bundle replaces the old bundle at the same edge (full throughput, no bubble).

Decomposition:
- Package r500_ctrl_pkg:
  - opcode localparams
  - ALUOp and RegSrc encodings
  - ValidReg bit positions
  - packed control-bundle typedef
- Sub-module ctrl_decode: purely combinational, maps instr and EN_M to the bundle plus out_illegal.
- The stage module owns the register, handshake, hazard logic and counter.

Test Plan:
- Reset mid-stream with out_valid=1 and a held LOAD: drop rst_n asynchronously -> out_valid=0 and illegal_cnt=0 before the next edge.
- Stream ADD, LW x5, SW with out_ready=1 -> three back-to-back outputs. LW gives alu_op=1, reg_src=1, mem_read=1, valid_reg=011. SW gives mem_write=1, reg_write=0.
- LW x5,0(x1) followed by ADD x6,x5,x2 -> in_ready=0 for one cycle, one bubble (out_valid=0), then ADD issues. Repeat with rd=x0 -> no bubble.
- Hold out_ready=0 for 3 cycles with BEQ held -> fields stable, in_ready=0. Release -> BEQ transfers with alu_op=2, branch=1.
- Flush asserted while JAL is held and in_valid=1 -> next cycle out_valid=0, nothing accepted, illegal_cnt unchanged.
- Two checks on instr with opcode 1111111, and on funct7=0000001 with EN_M=0 versus EN_M=1:
  - Illegal encodings -> out_illegal=1 and illegal_cnt increments.
  - Legal MUL with EN_M=1 -> out_muldiv=1, reg_write=1.
  - With CNT_W=2, feed 5 illegals -> illegal_cnt saturates at 3.
